// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core LSU and an
// external loader/DMA requester. The core has priority. A starvation counter
// forces one external grant after STARVE consecutive denied cycles, and the
// core is stalled whenever it loses the port.
module dmem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STARVE = 4,
  parameter int SCW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  // core load/store path
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  // external requester
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // statistics
  output logic [SCW-1:0] stall_cnt
);

  // The starvation counter must be able to hold the value STARVE itself.
  localparam int STW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [STW-1:0] STARVE_V = STW'(STARVE);

  // One memory-side access as presented by either requester.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_req_t;

  typedef enum logic [0:0] {
    CORE_PRI  = 1'b0,
    EXT_FORCE = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [STW-1:0] starve_cnt, starve_nxt;
  logic           gnt_core, gnt_ext;
  port_req_t      core_p, ext_p, sel_p;

  assign core_p = '{we: core_we, addr: core_addr, wdata: core_wdata};
  assign ext_p  = '{we: ext_we,  addr: ext_addr,  wdata: ext_wdata};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CORE_PRI;
    else      state <= state_nxt;
  end

  // Grant selection and next-state logic. While reset is asserted, every
  // grant is held off so that an access in progress is dropped before the
  // memory can sample it.
  always_comb begin
    gnt_core   = 1'b0;
    gnt_ext    = 1'b0;
    starve_nxt = '0;
    state_nxt  = CORE_PRI;
    if (rst) begin
      if (state == EXT_FORCE && ext_req) gnt_ext  = 1'b1;
      else if (core_req)                 gnt_core = 1'b1;
      else if (ext_req)                  gnt_ext  = 1'b1;
    end
    // A pending ext request that missed the port ages; anything else clears.
    if (ext_req && !gnt_ext)
      starve_nxt = (starve_cnt == STARVE_V) ? starve_cnt : starve_cnt + 1'b1;
    // A forced grant lasts exactly one cycle, whether or not ext still wants it.
    if (state == CORE_PRI && starve_nxt == STARVE_V) state_nxt = EXT_FORCE;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt <= '0;
    else      starve_cnt <= starve_nxt;
  end

  assign ext_gnt    = gnt_ext;
  assign core_stall = rst & core_req & ~gnt_core;

  // Port mux: the granted requester drives the memory; idle drives zeros.
  always_comb begin
    sel_p = '0;
    if (gnt_core)     sel_p = core_p;
    else if (gnt_ext) sel_p = ext_p;
  end

  assign mem_en     = gnt_core | gnt_ext;
  assign mem_we     = sel_p.we;
  assign mem_addr   = sel_p.addr;
  assign mem_wdata  = sel_p.wdata;
  assign core_rdata = mem_rdata;

  // External read return: capture memory data one edge after a read grant.
  // ext_rdata keeps the last returned word between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= gnt_ext & ~ext_we;
      if (gnt_ext && !ext_we) ext_rdata <= mem_rdata;
    end
  end

  // Saturating count of cycles the core spent stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_cnt <= '0;
    else if (core_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
